// File: rtl/zxuno_regs_pkg.sv
// ---------------------------------------------------------------------------
// zxuno_regs_pkg
// Shared definitions for the ZX-UNO string-ID register peripheral:
//   - default register addresses of the streaming data and select registers
//   - the NUL terminator byte
//   - state encoding of the read-access tracker
//   - helper that maps (string, byte) to a bit offset in the packed ROM image
// ---------------------------------------------------------------------------
package zxuno_regs_pkg;

  localparam logic [7:0] ADDR_COREID = 8'hFF;  // streaming data register
  localparam logic [7:0] ADDR_STRSEL = 8'hFE;  // select / status register
  localparam logic [7:0] NUL_BYTE    = 8'h00;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_READING = 1'b1
  } acc_state_t;

  // Bit offset of byte k of string s in a packed image of strlen-byte strings.
  function automatic int unsigned rom_bit_index(input int unsigned s,
                                                input int unsigned k,
                                                input int unsigned strlen);
    return (s * strlen + k) * 32'd8;
  endfunction

endpackage

// File: rtl/zxuno_strid_if.sv
// ---------------------------------------------------------------------------
// zxuno_strid_if
// ZX-UNO register-bus slice seen by the string-ID peripheral.
//   zxuno_addr       latched register address
//   zxuno_regrd      high while the CPU reads the addressed register
//   zxuno_regwr      one-cycle pulse on a CPU register write
//   din              CPU write data
//   regaddr_changed  one-cycle pulse when zxuno_addr is rewritten
//   dout             registered read data
//   oe_n             active-low output enable (combinational)
// master = CPU/bus side, slave = peripheral side.
// ---------------------------------------------------------------------------
interface zxuno_strid_if;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic       regaddr_changed;
  logic [7:0] dout;
  logic       oe_n;

  modport master (
    output zxuno_addr, zxuno_regrd, zxuno_regwr, din, regaddr_changed,
    input  dout, oe_n
  );

  modport slave (
    input  zxuno_addr, zxuno_regrd, zxuno_regwr, din, regaddr_changed,
    output dout, oe_n
  );
endinterface

// File: rtl/zxuno_strrom.sv
// ---------------------------------------------------------------------------
// zxuno_strrom
// Read-only string table: NSTR strings of STRLEN bytes taken from the packed
// STR_INIT image, read combinationally (maps onto distributed ROM).
//   sel   in  4                string number
//   idx   in  $clog2(STRLEN)   byte index inside the string
//   data  out 8                rom[sel][idx]; NUL for sel >= NSTR
// ---------------------------------------------------------------------------
module zxuno_strrom
  import zxuno_regs_pkg::*;
#(
  parameter int unsigned                NSTR     = 32'd2,
  parameter int unsigned                STRLEN   = 32'd16,
  parameter logic [NSTR*STRLEN*8-1:0]   STR_INIT = '0
) (
  input  logic [3:0]                sel,
  input  logic [$clog2(STRLEN)-1:0] idx,
  output logic [7:0]                data
);

  // Table is sized to the full 4-bit select range so both indices are exact.
  logic [7:0] rom [16][STRLEN];

  // Unpack the ROM image; unused string slots read as NUL.
  always_comb begin
    for (int unsigned s = 0; s < 16; s++) begin
      for (int unsigned k = 0; k < STRLEN; k++) begin
        if (s < NSTR) begin
          rom[s][k] = STR_INIT[rom_bit_index(s, k, STRLEN) +: 8];
        end else begin
          rom[s][k] = NUL_BYTE;
        end
      end
    end
  end

  assign data = rom[sel][idx];

endmodule

// File: rtl/zxuno_strid.sv
// ---------------------------------------------------------------------------
// zxuno_strid
// Multi-string ID reader on the ZX-UNO register bus. Software picks a string
// through the select register and streams it through the data register; each
// completed data read advances the byte index (wrap or stick at NUL/end).
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    zxuno_strid_if.slave (address, rd/wr strobes, din, dout, oe_n)
// ---------------------------------------------------------------------------
module zxuno_strid
  import zxuno_regs_pkg::*;
#(
  parameter int unsigned              NSTR      = 32'd2,
  parameter int unsigned              STRLEN    = 32'd16,
  parameter logic [7:0]               DATA_ADDR = ADDR_COREID,
  parameter logic [7:0]               SEL_ADDR  = ADDR_STRSEL,
  parameter bit                       WRAP      = 1'b0,
  parameter logic [NSTR*STRLEN*8-1:0] STR_INIT  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  zxuno_strid_if.slave  bus
);

  localparam int unsigned   IW       = $clog2(STRLEN);
  localparam logic [IW-1:0] IDX_LAST = IW'(STRLEN - 32'd1);
  localparam logic [3:0]    NSTR_M1  = 4'(NSTR - 32'd1);
  localparam logic [4:0]    NSTR_W   = 5'(NSTR);

  acc_state_t    state, state_nxt;
  logic [IW-1:0] idx, idx_nxt, idx_adv;
  logic [3:0]    sel, sel_nxt;
  logic [7:0]    rom_byte;
  logic [7:0]    rd_data;
  logic          data_rd, sel_wr, rewind;

  zxuno_strrom #(
    .NSTR     (NSTR),
    .STRLEN   (STRLEN),
    .STR_INIT (STR_INIT)
  ) u_rom (
    .sel  (sel),
    .idx  (idx),
    .data (rom_byte)
  );

  assign data_rd = bus.zxuno_regrd && (bus.zxuno_addr == DATA_ADDR);
  assign sel_wr  = bus.zxuno_regwr && (bus.zxuno_addr == SEL_ADDR);
  // Re-pointing the bus at the data register or writing the selector both
  // restart the string from its first byte.
  assign rewind  = (bus.regaddr_changed && (bus.zxuno_addr == DATA_ADDR)) || sel_wr;

  assign bus.oe_n = !(bus.zxuno_regrd &&
                      ((bus.zxuno_addr == DATA_ADDR) || (bus.zxuno_addr == SEL_ADDR)));
  assign bus.dout = rd_data;

  // Index value after a completed read: wrap modulo STRLEN, or stick on NUL/last byte.
  always_comb begin
    idx_adv = idx;
    if (WRAP) begin
      idx_adv = idx + IW'(1'b1);
    end else if ((rom_byte == NUL_BYTE) || (idx == IDX_LAST)) begin
      idx_adv = idx;
    end else begin
      idx_adv = idx + IW'(1'b1);
    end
  end

  // Access tracker next state: rewind beats the completion advance; an access
  // completes on the first cycle the data read condition drops.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sel_nxt   = sel;
    if (sel_wr && ({1'b0, bus.din[3:0]} < NSTR_W)) begin
      sel_nxt = bus.din[3:0];
    end else begin
      sel_nxt = sel;
    end
    if (rewind) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_rd) begin
            state_nxt = ST_READING;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_READING: begin
          if (!data_rd) begin
            state_nxt = ST_IDLE;
            idx_nxt   = idx_adv;
          end else begin
            state_nxt = ST_READING;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Tracker state, byte index and string select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      sel   <= 4'h0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      sel   <= sel_nxt;
    end
  end

  // Registered read mux: status word on the select address, ROM byte otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else if (bus.zxuno_addr == SEL_ADDR) begin
      rd_data <= {NSTR_M1, sel};
    end else begin
      rd_data <= rom_byte;
    end
  end

endmodule

// File: tb/tb_zxuno_strid.sv
// ---------------------------------------------------------------------------
// tb_zxuno_strid
// Drives two differently parametrised instances with the same bus traffic:
//   dut_a: NSTR=2, STRLEN=16, WRAP=0, strings "T24-1", "XY"
//   dut_b: NSTR=3, STRLEN=4,  WRAP=1, strings "ABCD", "EFGH", "IJ\0L"
// ---------------------------------------------------------------------------
module tb_zxuno_strid;
  import zxuno_regs_pkg::*;

  localparam logic [127:0] A_S0  = 128'h0000_0000_0000_0000_0000_0031_2D34_3254;
  localparam logic [127:0] A_S1  = 128'h0000_0000_0000_0000_0000_0000_0000_5958;
  localparam logic [255:0] STR_A = {A_S1, A_S0};
  localparam logic [95:0]  STR_B = {32'h4C00_4A49, 32'h4847_4645, 32'h4443_4241};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr, din;
  logic       regrd, regwr, rchg;

  int checks   = 0;
  int failures = 0;

  zxuno_strid_if bus_a ();
  zxuno_strid_if bus_b ();

  assign bus_a.zxuno_addr = addr;      assign bus_b.zxuno_addr = addr;
  assign bus_a.zxuno_regrd = regrd;    assign bus_b.zxuno_regrd = regrd;
  assign bus_a.zxuno_regwr = regwr;    assign bus_b.zxuno_regwr = regwr;
  assign bus_a.din = din;              assign bus_b.din = din;
  assign bus_a.regaddr_changed = rchg; assign bus_b.regaddr_changed = rchg;

  zxuno_strid #(.NSTR(2), .STRLEN(16), .DATA_ADDR(8'hFF), .SEL_ADDR(8'hFE),
                .WRAP(1'b0), .STR_INIT(STR_A))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  zxuno_strid #(.NSTR(3), .STRLEN(4), .DATA_ADDR(8'hFF), .SEL_ADDR(8'hFE),
                .WRAP(1'b1), .STR_INIT(STR_B))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  // ---------------- reference model (access-level) ----------------
  int m_sel [2];
  int m_idx [2];
  int nstr  [2] = '{2, 3};
  int slen  [2] = '{16, 4};
  bit wrap  [2] = '{1'b0, 1'b1};

  function automatic logic [7:0] ref_byte(input int d, input int s, input int k);
    if (d == 1) return STR_B[(s * 4 + k) * 8 +: 8];
    else        return STR_A[(s * 16 + k) * 8 +: 8];
  endfunction

  function automatic int next_idx(input int d);
    if (wrap[d]) return (m_idx[d] + 1) % slen[d];
    if (ref_byte(d, m_sel[d], m_idx[d]) == 8'h00 || m_idx[d] == slen[d] - 1) return m_idx[d];
    return m_idx[d] + 1;
  endfunction

  // ---------------- checking / bus tasks ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Read register a for 'hold' cycles, sample dout, then one idle cycle.
  task automatic rd(input logic [7:0] a, input int hold,
                    output logic [7:0] da, output logic [7:0] db);
    logic exp_oe;
    exp_oe = (a == 8'hFF || a == 8'hFE) ? 1'b0 : 1'b1;
    addr  = a;
    regrd = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    da = bus_a.dout;
    db = bus_b.dout;
    check("oe_n_a", {7'b0, bus_a.oe_n}, {7'b0, exp_oe});
    check("oe_n_b", {7'b0, bus_b.oe_n}, {7'b0, exp_oe});
    regrd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    din   = d;
    regwr = 1'b1;
    @(posedge clk); #1;
    regwr = 1'b0;
  endtask

  task automatic chg();
    addr = 8'hFF;
    rchg = 1'b1;
    @(posedge clk); #1;
    rchg = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; regrd = 1'b0; regwr = 1'b0; rchg = 1'b0;
    addr = 8'h00; din = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_sel = '{0, 0};
    m_idx = '{0, 0};
  endtask

  typedef enum int {OP_RD, OP_RDSEL, OP_WRSEL, OP_WRDATA, OP_CHG, OP_RDOTH} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] d;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t tab [27];

  initial begin
    logic [7:0] da, db, ea, eb;
    int         r, hold;

    tab[0]  = '{OP_RD,     8'h00, 8'h54, 8'h41};  // T / A
    tab[1]  = '{OP_RD,     8'h00, 8'h32, 8'h42};  // 2 / B
    tab[2]  = '{OP_RD,     8'h00, 8'h34, 8'h43};  // 4 / C
    tab[3]  = '{OP_RD,     8'h00, 8'h2D, 8'h44};  // - / D
    tab[4]  = '{OP_RD,     8'h00, 8'h31, 8'h41};  // 1 / A (wrap)
    tab[5]  = '{OP_RD,     8'h00, 8'h00, 8'h42};  // NUL / B
    tab[6]  = '{OP_RD,     8'h00, 8'h00, 8'h43};  // NUL sticks / C
    tab[7]  = '{OP_WRSEL,  8'h01, 8'h00, 8'h00};
    tab[8]  = '{OP_RD,     8'h00, 8'h58, 8'h45};  // X / E
    tab[9]  = '{OP_RD,     8'h00, 8'h59, 8'h46};  // Y / F
    tab[10] = '{OP_RDSEL,  8'h00, 8'h11, 8'h21};
    tab[11] = '{OP_WRSEL,  8'h07, 8'h00, 8'h00};  // out of range: sel kept, rewind
    tab[12] = '{OP_RD,     8'h00, 8'h58, 8'h45};
    tab[13] = '{OP_RDSEL,  8'h00, 8'h11, 8'h21};
    tab[14] = '{OP_WRSEL,  8'hF2, 8'h00, 8'h00};  // high nibble ignored
    tab[15] = '{OP_RDSEL,  8'h00, 8'h11, 8'h22};
    tab[16] = '{OP_RD,     8'h00, 8'h58, 8'h49};  // X / I
    tab[17] = '{OP_RD,     8'h00, 8'h59, 8'h4A};  // Y / J
    tab[18] = '{OP_RD,     8'h00, 8'h00, 8'h00};
    tab[19] = '{OP_RD,     8'h00, 8'h00, 8'h4C};  // stick / L
    tab[20] = '{OP_RD,     8'h00, 8'h00, 8'h49};  // stick / I (wrap)
    tab[21] = '{OP_WRSEL,  8'h00, 8'h00, 8'h00};
    tab[22] = '{OP_RD,     8'h00, 8'h54, 8'h41};
    tab[23] = '{OP_WRDATA, 8'h55, 8'h00, 8'h00};  // ignored
    tab[24] = '{OP_RD,     8'h00, 8'h32, 8'h42};
    tab[25] = '{OP_CHG,    8'h00, 8'h00, 8'h00};  // rewind
    tab[26] = '{OP_RD,     8'h00, 8'h54, 8'h41};

    // ---- reset state ----
    do_reset();
    check("reset_dout_a", bus_a.dout, 8'h00);
    check("reset_dout_b", bus_b.dout, 8'h00);
    check("reset_oe_n_a", {7'b0, bus_a.oe_n}, 8'h01);

    // ---- directed table ----
    for (int i = 0; i < 27; i++) begin
      case (tab[i].op)
        OP_RD:     begin rd(8'hFF, 1, da, db); check($sformatf("tab%0d_a", i), da, tab[i].exp_a);
                         check($sformatf("tab%0d_b", i), db, tab[i].exp_b); end
        OP_RDSEL:  begin rd(8'hFE, 1, da, db); check($sformatf("tab%0d_a", i), da, tab[i].exp_a);
                         check($sformatf("tab%0d_b", i), db, tab[i].exp_b); end
        OP_WRSEL:  wr(8'hFE, tab[i].d);
        OP_WRDATA: wr(8'hFF, tab[i].d);
        OP_CHG:    chg();
        default:   chg();
      endcase
    end

    // ---- long read advances once ----
    do_reset();
    rd(8'hFF, 10, da, db);
    check("long_rd_a", da, 8'h54);
    check("long_rd_b", db, 8'h41);
    rd(8'hFF, 1, da, db);
    check("after_long_a", da, 8'h32);
    check("after_long_b", db, 8'h42);

    // ---- rewind in the completion cycle wins over the advance ----
    addr = 8'hFF; regrd = 1'b1;
    @(posedge clk); #1;
    check("pre_rewind_a", bus_a.dout, 8'h34);
    check("pre_rewind_b", bus_b.dout, 8'h43);
    regrd = 1'b0; rchg = 1'b1;
    @(posedge clk); #1;
    rchg = 1'b0;
    rd(8'hFF, 1, da, db);
    check("rewind_cmpl_a", da, 8'h54);
    check("rewind_cmpl_b", db, 8'h41);

    // ---- reset in the middle of a read ----
    wr(8'hFE, 8'h01);
    rd(8'hFF, 1, da, db);
    check("sel1_a", da, 8'h58);
    check("sel1_b", db, 8'h45);
    addr = 8'hFF; regrd = 1'b1;
    @(posedge clk); #1;
    check("midrd_a", bus_a.dout, 8'h59);
    check("midrd_b", bus_b.dout, 8'h46);
    rst_n = 1'b0;
    #1;
    check("rst_dout_a", bus_a.dout, 8'h00);
    check("rst_dout_b", bus_b.dout, 8'h00);
    check("rst_oe_rd", {7'b0, bus_a.oe_n}, 8'h00);
    regrd = 1'b0;
    #1;
    check("rst_oe_idle", {7'b0, bus_a.oe_n}, 8'h01);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(8'hFE, 1, da, db);
    check("rst_sel_a", da, 8'h10);
    check("rst_sel_b", db, 8'h20);
    rd(8'hFF, 1, da, db);
    check("rst_first_a", da, 8'h54);
    check("rst_first_b", db, 8'h41);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        hold = $urandom_range(1, 4);
        ea = ref_byte(0, m_sel[0], m_idx[0]);
        eb = ref_byte(1, m_sel[1], m_idx[1]);
        rd(8'hFF, hold, da, db);
        m_idx[0] = next_idx(0);
        m_idx[1] = next_idx(1);
        check("rnd_data_a", da, ea);
        check("rnd_data_b", db, eb);
      end else if (r == 5) begin
        rd(8'hFE, 1, da, db);
        check("rnd_sel_a", da, {4'(nstr[0] - 1), 4'(m_sel[0])});
        check("rnd_sel_b", db, {4'(nstr[1] - 1), 4'(m_sel[1])});
      end else if (r == 6) begin
        logic [7:0] v;
        v = 8'($urandom);
        wr(8'hFE, v);
        for (int d = 0; d < 2; d++) begin
          if (int'(v[3:0]) < nstr[d]) m_sel[d] = int'(v[3:0]);
          m_idx[d] = 0;
        end
      end else if (r == 7) begin
        wr(8'hFF, 8'($urandom));
      end else if (r == 8) begin
        chg();
        m_idx = '{0, 0};
      end else begin
        ea = ref_byte(0, m_sel[0], m_idx[0]);
        eb = ref_byte(1, m_sel[1], m_idx[1]);
        rd(8'($urandom_range(0, 253)), 1, da, db);
        check("rnd_other_a", da, ea);
        check("rnd_other_b", db, eb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
